cprv_ram_arb: RTL and testbench

//   Shares one cprv single-port RAM valid/ready pipeline between two requesters:
//     - IF: instruction fetch, read-only.
//     - LS: load/store, read or write.

---
 rtl/cprv_ram_arb_pkg.sv | 4 +
 rtl/cprv_ram_arb_if.sv | 24 ++
 rtl/cprv_ram_arb_idq.sv | 42 ++++
 rtl/cprv_ram_arb.sv | 58 +++++
 tb/tb_cprv_ram_arb.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cprv_ram_arb_pkg.sv
// cprv_ram_arb_pkg: requester IDs shared by the RAM arbiter, its owner tracker and the bench
package cprv_ram_arb_pkg;
  typedef enum logic {REQ_IF = 1'b0, REQ_LS = 1'b1} req_id_t;
endpackage

// File: rtl/cprv_ram_arb_if.sv
// cprv_ram_arb_if: requester and RAM valid/ready channels around the RAM arbiter
interface cprv_ram_arb_if #(parameter int ADDR_WIDTH = 12, parameter int DATA_WIDTH = 64);
  logic                  if_valid_i, if_ready_o, if_valid_o, if_ready_i;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  ls_valid_i, ls_ready_o, ls_w_en, ls_valid_o, ls_ready_i;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0] ls_wdata, ls_rdata;
  logic                  ram_valid_o, ram_ready_i, ram_w_en, ram_valid_i, ram_ready_o;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
  modport slave (
    input  if_valid_i, if_addr, if_ready_i, ls_valid_i, ls_w_en, ls_addr, ls_wdata, ls_ready_i,
           ram_ready_i, ram_valid_i, ram_rdata,
    output if_ready_o, if_valid_o, if_rdata, ls_ready_o, ls_valid_o, ls_rdata,
           ram_valid_o, ram_w_en, ram_addr, ram_wdata, ram_ready_o
  );
  modport master (
    output if_valid_i, if_addr, if_ready_i, ls_valid_i, ls_w_en, ls_addr, ls_wdata, ls_ready_i,
           ram_ready_i, ram_valid_i, ram_rdata,
    input  if_ready_o, if_valid_o, if_rdata, ls_ready_o, ls_valid_o, ls_rdata,
           ram_valid_o, ram_w_en, ram_addr, ram_wdata, ram_ready_o
  );
endinterface

// File: rtl/cprv_ram_arb_idq.sv
// cprv_ram_arb_idq: in-order owner-ID FIFO for issued-but-unreturned RAM accesses
module cprv_ram_arb_idq
  import cprv_ram_arb_pkg::*;
#(parameter int DEPTH = 2)
(
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  req_id_t din,
  output req_id_t head,
  output logic    full,
  output logic    empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  req_id_t       mem [DEPTH];
  logic [PW-1:0] wp, rp, wp_n, rp_n;
  logic [CW-1:0] cnt;
  logic          wr, rd;
  always_comb begin
    empty = cnt == '0;
    full = cnt == CW'(DEPTH);
    rd = pop && !empty;
    wr = push && (!full || rd);
    wp_n = wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
    rp_n = rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
    head = mem[rp];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) mem[wp] <= din;
      if (wr) wp <= wp_n;
      if (rd) rp <= rp_n;
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/cprv_ram_arb.sv
// cprv_ram_arb: shares one RAM pipeline between IF and LS with in-order response steering; CPRV_RAM_ARB_RR_EN selects round-robin
module cprv_ram_arb
  import cprv_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_OUTST  = 2
)
(
  input logic           clk,
  input logic           rst,
  cprv_ram_arb_if.slave bus
);
  req_id_t               gnt, head;
  logic                  full, empty, ok, issue, pop;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
`ifdef CPRV_RAM_ARB_RR_EN
  req_id_t last;
  always_ff @(posedge clk) begin
    if (rst) last <= REQ_IF;
    else if (issue) last <= gnt;
  end
  always_comb gnt = (bus.if_valid_i && bus.ls_valid_i) ? (last == REQ_LS ? REQ_IF : REQ_LS)
                                                       : (bus.ls_valid_i ? REQ_LS : REQ_IF);
`else
  always_comb gnt = bus.ls_valid_i ? REQ_LS : REQ_IF;
`endif
  always_comb begin
    ok = !rst && !full;
    bus.ram_valid_o = (bus.if_valid_i || bus.ls_valid_i) && ok;
    bus.if_ready_o = ok && bus.ram_ready_i && gnt == REQ_IF;
    bus.ls_ready_o = ok && bus.ram_ready_i && gnt == REQ_LS;
    issue = bus.ram_valid_o && bus.ram_ready_i;
    addr = gnt == REQ_LS ? bus.ls_addr : bus.if_addr;
    wdata = bus.ls_wdata;
    bus.ram_addr = addr;
    bus.ram_wdata = wdata;
    bus.ram_w_en = gnt == REQ_LS && bus.ls_w_en;
    // with nothing tracked the RAM side is always accepted, so stray responses drain away
    bus.ram_ready_o = !rst && (empty || (head == REQ_IF ? bus.if_ready_i : bus.ls_ready_i));
    bus.if_valid_o = !rst && !empty && head == REQ_IF && bus.ram_valid_i;
    bus.ls_valid_o = !rst && !empty && head == REQ_LS && bus.ram_valid_i;
    bus.if_rdata = bus.ram_rdata;
    bus.ls_rdata = bus.ram_rdata;
    pop = bus.ram_valid_i && bus.ram_ready_o && !empty;
  end
  cprv_ram_arb_idq #(.DEPTH(MAX_OUTST)) u_idq (
    .clk(clk),
    .rst(rst),
    .push(issue),
    .pop(pop),
    .din(gnt),
    .head(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_cprv_ram_arb.sv
// tb_cprv_ram_arb: scoreboard bench for the RAM arbiter with a latency-1 in-order RAM model
`timescale 1ns/1ps
module tb_cprv_ram_arb;
  import cprv_ram_arb_pkg::*;
  localparam int AW = 12, DW = 64, MO = 2;
  typedef struct {req_id_t id; logic w; logic [DW-1:0] d;} exp_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  cprv_ram_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  cprv_ram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0, ls_acks = 0;
  logic [DW-1:0] last_if_d = '0;
  exp_t sbq [$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] ram [int];
  logic [DW-1:0] rq [$];
  logic rv = 0;
  logic [DW-1:0] rd = '0;
  assign bus.ram_valid_i = rv;
  assign bus.ram_rdata = rd;
  function automatic logic [DW-1:0] pat(input int a);
    return 64'hC0DE_5A00_0000_0000 | 64'(a);
  endfunction
  function automatic logic [DW-1:0] rmem(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rv && bus.ram_ready_o) void'(rq.pop_front());
    if (bus.ram_valid_o && bus.ram_ready_i) begin
      if (bus.ram_w_en) ram[int'(bus.ram_addr)] = bus.ram_wdata;
      rq.push_back(bus.ram_w_en ? '0 : (ram.exists(int'(bus.ram_addr)) ? ram[int'(bus.ram_addr)] : pat(int'(bus.ram_addr))));
    end
    rv <= rq.size() != 0;
    rd <= rq.size() != 0 ? rq[0] : '0;
  end
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_out", {bus.if_ready_o, bus.ls_ready_o, bus.ram_valid_o, bus.if_valid_o, bus.ls_valid_o, bus.ram_ready_o}, 0);
        sbq.delete();
      end else begin
        chk("dual_rsp", bus.if_valid_o & bus.ls_valid_o, 0);
        if (!bus.ram_valid_i) chk("idle_rsp", bus.if_valid_o | bus.ls_valid_o, 0);
        else if (sbq.size() == 0) begin
          chk("drop_rdy", bus.ram_ready_o, 1);
          chk("stray_rsp", bus.if_valid_o | bus.ls_valid_o, 0);
        end else begin
          e = sbq[0];
          chk("rsp_port", {bus.if_valid_o, bus.ls_valid_o}, e.id == REQ_IF ? 2'b10 : 2'b01);
          chk("ram_rdy", bus.ram_ready_o, e.id == REQ_IF ? bus.if_ready_i : bus.ls_ready_i);
          if ((bus.if_valid_o && bus.if_ready_i) || (bus.ls_valid_o && bus.ls_ready_i)) begin
            void'(sbq.pop_front());
            if (!e.w) chk("rsp_data", bus.if_valid_o ? bus.if_rdata : bus.ls_rdata, e.d);
            if (bus.if_valid_o) last_if_d = bus.if_rdata;
            else if (e.w) ls_acks++;
          end
        end
        if (bus.ram_valid_o && bus.ram_ready_i) begin
          if (bus.if_valid_i && bus.if_ready_o) begin
            chk("if_req", {bus.ram_w_en, bus.ram_addr}, {1'b0, bus.if_addr});
            sbq.push_back('{REQ_IF, 1'b0, rmem(int'(bus.if_addr))});
          end else if (bus.ls_valid_i && bus.ls_ready_o) begin
            chk("ls_req", {bus.ram_w_en, bus.ram_addr}, {bus.ls_w_en, bus.ls_addr});
            if (bus.ls_w_en) begin
              chk("ls_wdata", bus.ram_wdata, bus.ls_wdata);
              ref_mem[int'(bus.ls_addr)] = bus.ls_wdata;
            end
            sbq.push_back('{REQ_LS, bus.ls_w_en, bus.ls_w_en ? '0 : rmem(int'(bus.ls_addr))});
          end else chk("issue_owner", (bus.if_valid_i & bus.if_ready_o) | (bus.ls_valid_i & bus.ls_ready_o), 1);
        end
      end
    end
  endtask
  task automatic req(input req_id_t id, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic done = 0;
    @(posedge clk); #1;
    if (id == REQ_IF) begin
      bus.if_valid_i = 1;
      bus.if_addr = a;
    end else begin
      bus.ls_valid_i = 1;
      bus.ls_w_en = w;
      bus.ls_addr = a;
      bus.ls_wdata = d;
    end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = id == REQ_IF ? bus.if_ready_o : bus.ls_ready_o;
    end
    chk("req_accept", done, 1);
    @(posedge clk); #1;
    if (id == REQ_IF) bus.if_valid_i = 0;
    else bus.ls_valid_i = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || bus.ram_valid_i) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] g_exp [4];
    int n0;
    bus.if_valid_i = 0; bus.if_addr = '0; bus.if_ready_i = 1;
    bus.ls_valid_i = 0; bus.ls_w_en = 0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_ready_i = 1;
    bus.ram_ready_i = 1;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst = 0;
    // single IF read
    @(posedge clk); #1;
    bus.if_valid_i = 1; bus.if_addr = 12'h010;
    @(negedge clk);
    chk("t1_if_rdy", bus.if_ready_o, 1);
    chk("t1_ls_rdy", bus.ls_ready_o, 0);
    chk("t1_addr", bus.ram_addr, 12'h010);
    chk("t1_wen", bus.ram_w_en, 0);
    @(posedge clk); #1;
    bus.if_valid_i = 0;
    drain();
    chk("t1_data", last_if_d, pat(12'h010));
    // contention for four cycles
`ifdef CPRV_RAM_ARB_RR_EN
    g_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    g_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    @(posedge clk); #1;
    bus.if_valid_i = 1; bus.if_addr = 12'h100;
    bus.ls_valid_i = 1; bus.ls_w_en = 0; bus.ls_addr = 12'h200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_gnt", {bus.if_ready_o, bus.ls_ready_o}, g_exp[i]);
      @(posedge clk); #1;
    end
    bus.if_valid_i = 0; bus.ls_valid_i = 0;
    drain();
    // store then load the same word
    n0 = ls_acks;
    req(REQ_LS, 1, 12'h020, 64'hDEAD);
    req(REQ_IF, 0, 12'h020, '0);
    drain();
    chk("t3_ack", ls_acks - n0, 1);
    chk("t3_rd", last_if_d, 64'hDEAD);
    // fill the tracker while IF responses are held off
    bus.if_ready_i = 0;
    req(REQ_IF, 0, 12'h300, '0);
    req(REQ_IF, 0, 12'h301, '0);
    @(posedge clk); #1;
    bus.ls_valid_i = 1; bus.ls_w_en = 0; bus.ls_addr = 12'h302;
    bus.if_valid_i = 1; bus.if_addr = 12'h303;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_full", {bus.if_ready_o, bus.ls_ready_o, bus.ram_valid_o}, 0);
      chk("t4_head", bus.if_valid_o, 1);
      @(posedge clk); #1;
    end
    bus.if_ready_i = 1;
    @(negedge clk);
    chk("t4_pop", bus.if_valid_o & bus.ram_ready_o, 1);
    @(negedge clk);
    chk("t4_resume", {bus.ram_valid_o, bus.ls_ready_o}, 2'b11);
    @(posedge clk); #1;
    bus.ls_valid_i = 0; bus.if_valid_i = 0;
    req(REQ_IF, 0, 12'h303, '0);
    drain();
    // reset with two accesses in flight
    bus.if_ready_i = 0;
    req(REQ_IF, 0, 12'h400, '0);
    req(REQ_IF, 0, 12'h401, '0);
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    bus.if_ready_i = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_quiet", {bus.if_valid_o, bus.ls_valid_o}, 0);
      if (bus.ram_valid_i) chk("t5_drop", bus.ram_ready_o, 1);
    end
    chk("t5_drained", bus.ram_valid_i, 0);
    req(REQ_IF, 0, 12'h011, '0);
    drain();
    chk("t5_after", last_if_d, pat(12'h011));
    // IF response stuck behind a stalled LS response
    bus.ls_ready_i = 0;
    req(REQ_IF, 0, 12'h040, '0);
    req(REQ_LS, 0, 12'h050, '0);
    req(REQ_IF, 0, 12'h060, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_block", {bus.if_valid_o, bus.ls_valid_o}, 2'b01);
    end
    @(posedge clk); #1;
    bus.ls_ready_i = 1;
    drain();
    chk("t6_last", last_if_d, pat(12'h060));
    // random mix over a small address window so loads hit earlier stores
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) req(REQ_IF, 0, AW'($urandom_range(0, 15)), '0);
      else req(REQ_LS, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), {$urandom, $urandom});
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
